fetch_queue: RTL

Decoupling queue between the IF stage (PC generator plus synchronous instruction ROM) and the ID stage. It captures each fetched PC/instruction pair, buffers up to DEPTH of them, and presents them in order to ID with a valid/ready handshake. Its not-ready output is the IF stall source. A taken branch resolved downstream flushes every buffered entry so that no wrong-path instruction reaches decode.

---
 rtl/fetch_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: in-order IF->ID decoupling queue for fetched {pc, inst} pairs,
// with a flush that discards every buffered entry.
// Latency: one cycle. A pair accepted on edge N is visible on out_* in cycle N+1.
// Backpressure: in_ready is low only when full. It is taken from registered count alone,
// so a same-cycle dequeue never reopens a full queue.
//
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   flush                          drop all buffered and incoming pairs
//   in_valid/in_ready, in_pc/in_inst     IF side; IF stalls its PC on !in_ready
//   out_valid/out_ready, out_pc/out_inst ID side; out_pc/out_inst read 0 (a NOP) when empty
//   out_adel                       head PC misaligned (only with FETCH_QUEUE_ADEL_EN)
//
// Optional feature macro: FETCH_QUEUE_ADEL_EN adds a per-entry misaligned-PC flag.
// A flagged entry stores inst = 0.
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
  input  logic              out_ready
`ifdef FETCH_QUEUE_ADEL_EN
  ,
  output logic              out_adel
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  occ_t              occ;

  logic              enq;
  logic              deq;
  logic [DATA_W-1:0] wr_inst;

  // Occupancy is decoded from the registered count only. This keeps in_ready free of
  // any combinational path from out_ready or in_*.
  always_comb begin
    occ = OCC_PARTIAL;
    if (count == '0) begin
      occ = OCC_EMPTY;
    end else if (count == FULL_CNT) begin
      occ = OCC_FULL;
    end
  end

  assign in_ready  = (occ != OCC_FULL);
  assign out_valid = (occ != OCC_EMPTY);

  // Flush overrides both sides. A handshake during a flush cycle is neither an enqueue
  // nor a dequeue.
  assign enq = in_valid  && in_ready  && !flush;
  assign deq = out_valid && out_ready && !flush;

`ifdef FETCH_QUEUE_ADEL_EN
  logic [DEPTH-1:0] adel_mem;
  logic             in_adel;

  assign in_adel = (in_pc[1:0] != 2'b00);
  // A misaligned fetch must not present the ROM data to decode, so it is stored as a NOP.
  assign wr_inst = in_adel ? '0 : in_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adel_mem <= '0;
    end else if (enq) begin
      adel_mem[wr_ptr] <= in_adel;
    end
  end

  assign out_adel = out_valid && adel_mem[rd_ptr];
`else
  assign wr_inst = in_inst;
`endif

  // Entry storage. Flush does not clear the entries; they go stale behind out_valid=0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (enq) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= wr_inst;
    end
  end

  // Pointers wrap through natural overflow because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // An empty queue presents a NOP so ID never sees stale data.
  assign out_pc   = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_inst = out_valid ? inst_mem[rd_ptr] : '0;

endmodule
